// File: rtl/bit_unpacker_8x.sv
// Byte-to-bit serializer with a 2-entry input FIFO.
// Bits leave LSB first. Each frame ends with TAIL_BITS zero flush bits.
// bit_last marks the final bit of a frame.
module bit_unpacker_8x #(
  parameter int TAIL_BITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       in_last,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_out,
  output logic       bit_last,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  // Index of the final flush bit. It only matters when the tail exists.
  localparam logic [3:0] TAIL_LAST = (TAIL_BITS > 0) ? 4'(TAIL_BITS - 1) : 4'd0;
  localparam bit         HAS_TAIL  = (TAIL_BITS > 0);

  // ---------------- input FIFO: {last, byte} ----------------
  logic [8:0] fifo_mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic [8:0] fifo_head;

  // Ready depends only on occupancy.
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign in_ready   = (count_reg < 2'd2);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_reg == 2'd0);
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  // Storage write. Reset does not clear it, because count_reg gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {in_last, in_byte};
  end

  // Pointers and occupancy. A push and a pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- output FSM ----------------
  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic       last_reg, last_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0] tail_cnt_reg, tail_cnt_next;
  logic       bit_valid_reg, bit_valid_next;
  logic       bit_out_reg, bit_out_next;
  logic       bit_last_reg, bit_last_next;
  logic       handshake;

  assign handshake = bit_valid_reg && bit_ready;

  // Next-state logic.
  // At the end of a non-last byte, the next byte loads on the same edge if one is queued.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    last_next     = last_reg;
    bit_cnt_next  = bit_cnt_reg;
    tail_cnt_next = tail_cnt_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shift_next   = fifo_head[7:0];
          last_next    = fifo_head[8];
          bit_cnt_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (handshake) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (last_reg) begin
              if (HAS_TAIL) begin
                tail_cnt_next = 4'd0;
                state_next    = TAIL;
              end else begin
                state_next = IDLE;
              end
            end else if (!fifo_empty) begin
              pop          = 1'b1;
              shift_next   = fifo_head[7:0];
              last_next    = fifo_head[8];
              bit_cnt_next = 3'd0;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      TAIL: begin
        if (handshake) begin
          tail_cnt_next = tail_cnt_reg + 4'd1;
          if (tail_cnt_reg == TAIL_LAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The outputs come from the next state, so they are valid on the same edge as the state.
  always_comb begin
    bit_valid_next = (state_next != IDLE);
    bit_out_next   = (state_next == DATA) && shift_next[0];
    bit_last_next  = ((state_next == TAIL) && (tail_cnt_next == TAIL_LAST)) ||
                     ((state_next == DATA) && !HAS_TAIL && last_next && (bit_cnt_next == 3'd7));
  end

  // State and registered-output update. Reset discards any partial byte or tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= 8'd0;
      last_reg      <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      tail_cnt_reg  <= 4'd0;
      bit_valid_reg <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      last_reg      <= last_next;
      bit_cnt_reg   <= bit_cnt_next;
      tail_cnt_reg  <= tail_cnt_next;
      bit_valid_reg <= bit_valid_next;
      bit_out_reg   <= bit_out_next;
      bit_last_reg  <= bit_last_next;
    end
  end

  assign bit_valid = bit_valid_reg;
  assign bit_out   = bit_out_reg;
  assign bit_last  = bit_last_reg;
  assign busy      = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_bit_unpacker_8x.sv
// Testbench for bit_unpacker_8x with two instances.
// u_dut uses TAIL_BITS=6 and a scoreboard queue. u_dut_z uses TAIL_BITS=0.
module tb_bit_unpacker_8x;

  localparam int MAIN_TAIL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_byte = 8'd0;
  logic       in_last = 1'b0;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic       bit_out;
  logic       bit_last;
  logic       busy;

  // zero-tail instance
  logic       z_in_valid = 1'b0;
  logic       z_in_ready;
  logic [7:0] z_in_byte = 8'd0;
  logic       z_in_last = 1'b0;
  logic       z_bit_valid;
  logic       z_bit_ready = 1'b1;
  logic       z_bit_out;
  logic       z_bit_last;
  logic       z_busy;

  bit_unpacker_8x #(.TAIL_BITS(MAIN_TAIL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
    .bit_last(bit_last), .busy(busy)
  );

  bit_unpacker_8x #(.TAIL_BITS(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_byte(z_in_byte), .in_last(z_in_last),
    .bit_valid(z_bit_valid), .bit_ready(z_bit_ready), .bit_out(z_bit_out),
    .bit_last(z_bit_last), .busy(z_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q [$];   // {bit, last}
  logic [1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor. It samples on the falling edge. A handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_bit", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("bit_out", {31'd0, bit_out}, {31'd0, mon_e[1]});
          check("bit_last", {31'd0, bit_last}, {31'd0, mon_e[0]});
        end
      end else if (!bit_valid) begin
        check("idle_out", {31'd0, bit_out}, 32'd0);
        check("idle_last", {31'd0, bit_last}, 32'd0);
      end
    end
  end

  // Offer one byte to the main instance and queue its expected bits.
  // The task returns #1 after the accepting edge with in_valid still high.
  task automatic push_byte(input logic [7:0] b, input logic l);
    bit ok;
    ok = 1'b0;
    in_byte  = b;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < 8; k++)
        exp_q.push_back({b[k], (l && (MAIN_TAIL == 0) && (k == 7))});
      if (l)
        for (int t = 0; t < MAIN_TAIL; t++)
          exp_q.push_back({1'b0, (t == MAIN_TAIL - 1)});
      $display("push byte %02h last %0d", b, l);
    end
    @(posedge clk);
    #1;
  endtask

  // Wait until every expected bit has been consumed, then confirm the block is idle.
  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_valid_after"}, {31'd0, bit_valid}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    logic [7:0] zb;
    int got;

    // Reset must act asynchronously, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, bit_valid}, 32'd0);
    check("rst_out", {31'd0, bit_out}, 32'd0);
    check("rst_last", {31'd0, bit_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 0xA5: latency and single-byte shift-out.
    @(posedge clk); #1;
    push_byte(8'hA5, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_e0_valid", {31'd0, bit_valid}, 32'd0);
    @(negedge clk);
    check("lat_e1_valid", {31'd0, bit_valid}, 32'd1);
    check("lat_e1_out", {31'd0, bit_out}, 32'd1);
    drain("a5");

    // 0x01 then 0x80 back-to-back: 16 bits with no bubble.
    @(posedge clk); #1;
    push_byte(8'h01, 1'b0);
    push_byte(8'h80, 1'b0);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bit_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("b2b_start_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("b2b_no_bubble", {31'd0, bit_valid}, 32'd1);
      @(negedge clk);
    end
    drain("b2b");

    // Back-pressure: one byte in the shifter and two in the FIFO.
    bit_ready = 1'b0;
    @(posedge clk); #1;
    push_byte(8'h3C, 1'b0);
    push_byte(8'h12, 1'b0);
    push_byte(8'h34, 1'b0);
    // The FIFO is full, so this byte must be refused.
    in_byte = 8'h77;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_hold", {31'd0, bit_valid}, 32'd1);
      check("bp_out_hold", {31'd0, bit_out}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bit_ready = 1'b1;
    drain("bp");

    // Two frames of 0xFF then 0x81, each followed by 6 tail zeros, with one idle cycle between them.
    @(posedge clk); #1;
    push_byte(8'hFF, 1'b1);
    push_byte(8'h81, 1'b1);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (exp_q.size() == 14) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frame_gap_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("frame_gap_valid", {31'd0, bit_valid}, 32'd0);
    @(negedge clk);
    check("frame_resume_valid", {31'd0, bit_valid}, 32'd1);
    drain("tail");

    // TAIL_BITS=0 instance: 0x80 as a last byte.
    zb = 8'h80;
    @(posedge clk); #1;
    check("z_in_ready", {31'd0, z_in_ready}, 32'd1);
    z_in_byte  = zb;
    z_in_last  = 1'b1;
    z_in_valid = 1'b1;
    @(posedge clk); #1;
    z_in_valid = 1'b0;
    $display("push byte %02h last 1 (zero-tail instance)", zb);
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (z_bit_valid) begin
        check("z_bit_out", {31'd0, z_bit_out}, {31'd0, zb[got]});
        check("z_bit_last", {31'd0, z_bit_last}, (got == 7) ? 32'd1 : 32'd0);
        got++;
      end
    end
    if (got != 8) check("z_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("z_valid_after", {31'd0, z_bit_valid}, 32'd0);

    // Asynchronous reset after 3 bits of 0xF0. None of the remaining bits may appear.
    @(posedge clk); #1;
    push_byte(8'hF0, 1'b0);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (exp_q.size() == 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("mid_rst_timeout", 32'd0, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bit_valid}, 32'd0);
    check("mid_rst_out", {31'd0, bit_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_byte(8'h0F, 1'b0);
    in_valid = 1'b0;
    drain("post_rst");

    // Quiet period. The monitor flags any stray bit.
    repeat (20) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
